instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Upstream neighbour of the instruction decoder.
- Owns the program counter and issues one-at-a-time read requests to instruction memory.
- Captures each returned word into a single-entry instruction register and presents it to the decoder through a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards any in-flight or held instruction from the old path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  read request to instruction memory
- imem_req_ready  input  1  memory accepts the request this cycle
- imem_req_addr  output  32  byte address of the request (always word aligned)
- imem_rsp_valid  input  1  read data valid; earliest one cycle after acceptance
- imem_rsp_data  input  32  returned instruction word
- redirect_valid  input  1  branch/jump taken; load a new PC
- redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0
- instr_valid  output  1  instruction register holds a valid instruction
- instr_ready  input  1  decoder consumes the instruction this cycle
- instr  output  32  held instruction word, feeds the decoder's instruction input
- instr_pc  output  32  PC of the held instruction

Behaviour:
- Reset (async assert, sync-release usage assumed by the system):
  - state=FETCH, pc=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
  - imem_req_valid is 0 while rst_n is low.
- At most one outstanding memory request.
- imem_req_valid = (state==FETCH) and rst_n; imem_req_addr = pc.
- imem_req_addr is stable while valid and not ready, except in the cycle after a redirect.
- States:
  - FETCH: request asserted.
    - Accepted and no redirect -> WAIT.
    - Accepted and redirect in the same cycle -> DISCARD, pc<=redirect_pc.
    - Not accepted and redirect -> stay FETCH, pc<=redirect_pc.
  - WAIT: awaiting the response.
    - rsp_valid and no redirect -> instr<=rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go FULL.
    - Redirect with rsp_valid in the same cycle -> drop the response, pc<=redirect_pc, go FETCH.
    - Redirect without rsp_valid -> pc<=redirect_pc, go DISCARD.
  - FULL: instr_valid=1, no request issued.
    - instr_ready and no redirect -> instr_valid<=0, go FETCH.
    - Redirect (with or without ready) -> instr_valid<=0, pc<=redirect_pc, go FETCH; the held instruction is lost.
  - DISCARD: waiting to drop the stale response.
    - rsp_valid -> drop it, go FETCH.
    - Redirect in DISCARD updates pc and stays in DISCARD (the same single stale response is still owed).
- Redirect has priority over every other event in every state.
- instr and instr_pc change only on capture; they hold their value while instr_valid=0.
- PC arithmetic is 32-bit modulo 2^32: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag raised.
- rsp_valid arriving in FETCH or FULL (protocol violation) is ignored; no state change.
- Unreachable state encodings -> FETCH on the next clock.
- Latency: with zero-wait memory (ready=1, response one cycle after acceptance), request to instr_valid is 2 cycles; steady-state throughput is 1 instruction per 3 cycles with ready held high.
- Reset asserted mid-request or mid-response: all state is cleared immediately; any later response is not tracked (memory is reset by the same rst_n).

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {FETCH, WAIT, FULL, DISCARD}
  - NOP_INSTR = 32'h0000_0013
  - PC_STEP = 32'd4
  - XLEN = 32 (also used by the decoder and ALU)
- No sub-module; PC register, instruction register and FSM stay in one module of roughly 150-200 lines.

Test Plan:
- Reset release, ready=1, memory returns 32'h0020_8033 one cycle after acceptance -> req addr 0x0; instr_valid rises 2 cycles after release; instr=0x00208033, instr_pc=0x0; next request addr 0x4.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 with addr constant; no state change; acceptance on cycle 6 -> WAIT.
- Redirect to 0x0000_0103 while in WAIT, then rsp arrives -> response dropped, instr_valid stays 0; next request addr is 0x0000_0100.
- instr_ready held 0 for 4 cycles while FULL -> instr and instr_pc stable, no request issued; ready=1 -> instr_valid falls the next cycle and a request for pc+4 issues.
- Redirect and instr_ready in the same cycle while FULL -> held instruction dropped, next request addr = redirect_pc.
- RESET_PC=32'hFFFF_FFFC, one fetch completes -> next request addr 32'h0000_0000; rst_n pulsed low during WAIT -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
//   fetch_state_t : fetch FSM state encoding
//   NOP_INSTR     : instruction register contents after reset (addi x0, x0, 0)
//   PC_STEP       : sequential PC increment in bytes
//   XLEN          : datapath width, shared with the decoder and ALU
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        FULL    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to instruction
// memory, holds the returned word in a single-entry instruction register and hands it to
// the decoder with a valid/ready handshake. Redirects replace the PC and discard any
// in-flight or held instruction from the old path.
//
// Ports:
//   clk, rst_n                     : clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr      : read request to instruction memory (word aligned)
//   imem_rsp_valid/data            : read response, earliest one cycle after acceptance
//   redirect_valid/redirect_pc     : taken branch/jump target (bits [1:0] ignored)
//   instr_valid/ready, instr       : held instruction to the decoder
//   instr_pc                       : PC of the held instruction
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ivalid_q, ivalid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ivalid_d = ivalid_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    // An accepted old-path request still owes one response.
                    state_d = imem_req_ready ? DISCARD : FETCH;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = imem_rsp_valid ? FETCH : DISCARD;
                end else if (imem_rsp_valid) begin
                    instr_d  = imem_rsp_data;
                    ipc_d    = pc_q;
                    ivalid_d = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    ivalid_d = 1'b0;
                    pc_d     = redirect_target;
                    state_d  = FETCH;
                end else if (instr_ready) begin
                    ivalid_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                // The stale response is dropped whether or not a redirect coincides;
                // only one response is ever owed.
                if (imem_rsp_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ivalid_q <= 1'b0;
            instr_q  <= NOP_INSTR;
            ipc_q    <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ivalid_q <= ivalid_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
        end
    end

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req_valid = (state_q == FETCH) && rst_n;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = ivalid_q;
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;

endmodule
